// File: rtl/stream_frame_sink.sv
// Streaming complex-sample frame sink: collects one SOP..EOP frame of LEN words into a
// buffer, holds it for a consumer until release, and reports framing and upstream errors.
module stream_frame_sink #(
  parameter int LEN = 256,
  parameter int DW  = 16,
  parameter int AW  = 8
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iSinkValid,
  output logic          oSinkReady,
  input  logic          iSinkSop,
  input  logic          iSinkEop,
  input  logic [DW-1:0] iSinkReal,
  input  logic [DW-1:0] iSinkImag,
  input  logic [1:0]    iSinkError,
  input  logic          iRelease,
  input  logic [AW-1:0] iReadAddr,
  output logic [DW-1:0] oReadReal,
  output logic [DW-1:0] oReadImag,
  output logic          oFrameReady,
  output logic [1:0]    oFrameErr,
  output logic          oUpErr,
  output logic [AW:0]   oWordCount
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, FULL} state_t;

  localparam int          CW       = AW + 1;
  localparam logic [AW:0] LAST_IDX = CW'(LEN - 1);
  localparam logic [AW:0] LEN_CNT  = CW'(LEN);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_SOP  = 2'b01;
  localparam logic [1:0] ERR_EARLY   = 2'b10;
  localparam logic [1:0] ERR_LONG    = 2'b11;

  // Reset asserts immediately but releases only after two clean iClk edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t          state;
  logic [AW:0]     count;
  logic            frame_ready;
  logic [1:0]      frame_err;
  logic            up_err;

  logic            xfer;
  logic            accept;
  logic [AW:0]     idx;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  logic [2*DW-1:0] mem [LEN];
  logic [2*DW-1:0] rd_data;

  assign oSinkReady = (state != FULL);
  assign xfer       = iSinkValid && oSinkReady;

  // A word belongs to a frame when it opens one (SOP) or continues one (RECV).
  // A SOP word always lands at index 0, restarting any frame in progress.
  assign accept  = xfer && ((state == IDLE && iSinkSop) || state == RECV);
  assign idx     = iSinkSop ? '0 : count;
  assign wr_en   = accept && (iSinkEop == (idx == LAST_IDX));
  assign wr_addr = idx[AW-1:0];

  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      frame_ready <= 1'b0;
      frame_err   <= ERR_NONE;
      up_err      <= 1'b0;
    end else begin
      if (xfer && iSinkError != 2'b00) up_err <= 1'b1;

      unique case (state)
        IDLE, RECV: begin
          if (xfer) begin
            if (!accept) begin
              frame_err <= ERR_NO_SOP;
            end else begin
              if (iSinkSop) frame_err <= (state == RECV) ? ERR_EARLY : ERR_NONE;
              // NOTE: later non-blocking assignments in this block override the SOP
              // error code above, so the frame outcome always wins.
              if (idx == LAST_IDX) begin
                if (iSinkEop) begin
                  state       <= FULL;
                  count       <= LEN_CNT;
                  frame_ready <= 1'b1;
                end else begin
                  state     <= DROP;
                  count     <= '0;
                  frame_err <= ERR_LONG;
                end
              end else if (iSinkEop) begin
                state     <= IDLE;
                count     <= '0;
                frame_err <= ERR_EARLY;
              end else begin
                state <= RECV;
                count <= idx + 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (xfer && iSinkEop) state <= IDLE;
        end
        FULL: begin
          if (iRelease) begin
            state       <= IDLE;
            count       <= '0;
            frame_ready <= 1'b0;
            up_err      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the frame buffer is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge iClk) begin
    if (wr_en) mem[wr_addr] <= {iSinkReal, iSinkImag};
  end

  // Registered read: a same-edge write to the same address yields the old word.
  always_ff @(posedge iClk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[iReadAddr];
  end

  assign oReadReal   = rd_data[2*DW-1:DW];
  assign oReadImag   = rd_data[DW-1:0];
  assign oFrameReady = frame_ready;
  assign oFrameErr   = frame_err;
  assign oUpErr      = up_err;
  assign oWordCount  = count;

endmodule

// File: tb/tb_stream_frame_sink.sv
// Self-checking bench for stream_frame_sink: directed scenarios plus randomized frames,
// all checked against a frame-level reference model kept in this file.
module tb_stream_frame_sink;

  localparam int LEN = 256;
  localparam int DW  = 16;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, sop, eop, rel;
  logic [DW-1:0] re, im;
  logic [1:0]    er;
  logic [AW-1:0] raddr;
  logic          ready, frame_ready, up_err;
  logic [DW-1:0] rd_re, rd_im;
  logic [1:0]    frame_err;
  logic [AW:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_frame_sink #(.LEN(LEN), .DW(DW), .AW(AW)) dut (
    .iClk(clk), .iReset_n(rst_n),
    .iSinkValid(valid), .oSinkReady(ready),
    .iSinkSop(sop), .iSinkEop(eop),
    .iSinkReal(re), .iSinkImag(im), .iSinkError(er),
    .iRelease(rel), .iReadAddr(raddr),
    .oReadReal(rd_re), .oReadImag(rd_im),
    .oFrameReady(frame_ready), .oFrameErr(frame_err),
    .oUpErr(up_err), .oWordCount(word_count)
  );

  // Reference model: frame-level view of what has been collected and held.
  logic [2*DW-1:0] m_buf [LEN];
  bit              m_in, m_drop, m_held, m_up;
  int              m_cnt;
  logic [1:0]      m_err;

  task automatic model_reset();
    m_in = 0; m_drop = 0; m_held = 0; m_up = 0; m_cnt = 0; m_err = 2'b00;
  endtask

  task automatic model_step(input logic v, s, e, input logic [DW-1:0] r, i,
                            input logic [1:0] ec, input logic rl);
    int pos;
    if (m_held) begin
      if (rl) begin m_held = 0; m_up = 0; m_cnt = 0; end
      return;
    end
    if (!v) return;
    if (ec != 2'b00) m_up = 1;
    if (m_drop) begin
      if (e) m_drop = 0;
      return;
    end
    if (s) begin
      m_err = m_in ? 2'b10 : 2'b00;
      pos = 0;
    end else if (m_in) begin
      pos = m_cnt;
    end else begin
      m_err = 2'b01;
      return;
    end
    if (e && pos == LEN - 1) begin
      m_buf[pos] = {r, i}; m_cnt = LEN; m_in = 0; m_held = 1;
    end else if (e) begin
      m_err = 2'b10; m_cnt = 0; m_in = 0;
    end else if (pos == LEN - 1) begin
      m_err = 2'b11; m_cnt = 0; m_in = 0; m_drop = 1;
    end else begin
      m_buf[pos] = {r, i}; m_cnt = pos + 1; m_in = 1;
    end
  endtask

  // One clock of stimulus; entered and left on a falling edge.
  task automatic drive(input logic v, s, e, input logic [DW-1:0] r, i,
                       input logic [1:0] ec, input logic rl);
    valid = v; sop = s; eop = e; re = r; im = i; er = ec; rel = rl;
    @(posedge clk);
    model_step(v, s, e, r, i, ec, rl);
    @(negedge clk);
    valid = 0; sop = 0; eop = 0; er = 2'b00; rel = 0;
  endtask

  task automatic send_frame(input int n, input int eop_at, input int err_at, input bit idx_data);
    for (int k = 0; k < n; k++)
      drive(1'b1, k == 0, k == eop_at,
            idx_data ? DW'(k) : DW'($urandom), idx_data ? (DW'(k) | 16'h8000) : DW'($urandom),
            (k == err_at) ? 2'b01 : 2'b00, 1'b0);
  endtask

  task automatic release_frame();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    n_cmp++; if (frame_err !== 2'b00) begin n_bad++; $display("FAIL reset_frame_err: got %b want 00", frame_err); end
    n_cmp++; if (up_err !== 1'b0) begin n_bad++; $display("FAIL reset_up_err: got %b want 0", up_err); end
    n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", word_count); end
    n_cmp++; if ({rd_re, rd_im} !== '0) begin n_bad++; $display("FAIL reset_read: got %h want 0", {rd_re, rd_im}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic test_good_frame();
    for (int k = 0; k < LEN; k++) begin
      drive(1'b1, k == 0, k == LEN - 1, DW'(k), DW'(k) | 16'h8000, 2'b00, 1'b0);
      if (k == LEN - 2) begin
        n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL good_early_ready: got %b want 0", frame_ready); end
      end
    end
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL good_frame_ready: got %b want 1", frame_ready); end
    n_cmp++; if (word_count !== 9'(LEN)) begin n_bad++; $display("FAIL good_count: got %0d want %0d", word_count, LEN); end
    n_cmp++; if (frame_err !== 2'b00) begin n_bad++; $display("FAIL good_frame_err: got %b want 00", frame_err); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL good_ready_full: got %b want 0", ready); end
    raddr = 8'd37;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({rd_re, rd_im} !== {16'd37, 16'h8025}) begin n_bad++; $display("FAIL good_read37: got %h want %h", {rd_re, rd_im}, {16'd37, 16'h8025}); end
    raddr = 8'd255;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({rd_re, rd_im} !== {16'd255, 16'h80ff}) begin n_bad++; $display("FAIL good_read255: got %h want %h", {rd_re, rd_im}, {16'd255, 16'h80ff}); end
  endtask

  task automatic test_backpressure();
    raddr = 8'd37;
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_held[%0d]: got %b want 0", k, ready); end
      drive(1'b1, k[0], k == 9, DW'($urandom), DW'($urandom), 2'b00, 1'b0);
    end
    n_cmp++; if (word_count !== 9'(LEN)) begin n_bad++; $display("FAIL bp_count_frozen: got %0d want %0d", word_count, LEN); end
    n_cmp++; if ({rd_re, rd_im} !== {16'd37, 16'h8025}) begin n_bad++; $display("FAIL bp_buf_frozen: got %h want %h", {rd_re, rd_im}, {16'd37, 16'h8025}); end
    release_frame();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %b want 1", ready); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL bp_frame_ready_release: got %b want 0", frame_ready); end
  endtask

  task automatic test_early_eop();
    logic [2*DW-1:0] old0;
    old0  = m_buf[0];
    raddr = 8'd0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, k == 0, k == 99, DW'(16'h1234 + k), DW'(16'h5678 + k), 2'b00, 1'b0);
      if (k == 0) begin
        n_cmp++; if ({rd_re, rd_im} !== old0) begin n_bad++; $display("FAIL rdw_old: got %h want %h", {rd_re, rd_im}, old0); end
      end
      if (k == 1) begin
        n_cmp++; if ({rd_re, rd_im} !== {16'h1234, 16'h5678}) begin n_bad++; $display("FAIL rdw_new: got %h want %h", {rd_re, rd_im}, {16'h1234, 16'h5678}); end
      end
    end
    n_cmp++; if (frame_err !== 2'b10) begin n_bad++; $display("FAIL early_err: got %b want 10", frame_err); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL early_frame_ready: got %b want 0", frame_ready); end
    n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL early_count: got %0d want 0", word_count); end
    send_frame(LEN, LEN - 1, -1, 1'b0);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL early_next_ready: got %b want 1", frame_ready); end
    n_cmp++; if (frame_err !== 2'b00) begin n_bad++; $display("FAIL early_next_err: got %b want 00", frame_err); end
    raddr = 8'd99;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({rd_re, rd_im} !== m_buf[99]) begin n_bad++; $display("FAIL early_next_read: got %h want %h", {rd_re, rd_im}, m_buf[99]); end
    release_frame();
  endtask

  task automatic test_restart();
    send_frame(50, -1, -1, 1'b0);
    for (int k = 0; k < LEN; k++) begin
      drive(1'b1, k == 0, k == LEN - 1, DW'(k), DW'(~k), 2'b00, 1'b0);
      if (k == 0) begin
        n_cmp++; if (frame_err !== 2'b10) begin n_bad++; $display("FAIL restart_err: got %b want 10", frame_err); end
        n_cmp++; if (word_count !== 9'd1) begin n_bad++; $display("FAIL restart_count: got %0d want 1", word_count); end
      end
    end
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL restart_complete: got %b want 1", frame_ready); end
    release_frame();
  endtask

  task automatic test_overlong();
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, k == 0, k == 299, DW'(k), DW'(k), 2'b00, 1'b0);
      if (k == LEN - 1) begin
        n_cmp++; if (frame_err !== 2'b11) begin n_bad++; $display("FAIL long_err: got %b want 11", frame_err); end
        n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL long_count: got %0d want 0", word_count); end
      end
    end
    n_cmp++; if (frame_ready !== 1'b0 || word_count !== '0) begin n_bad++; $display("FAIL long_discard: got ready=%b count=%0d want 0/0", frame_ready, word_count); end
    drive(1'b1, 1'b0, 1'b0, 16'h0bad, 16'h0bad, 2'b00, 1'b0);
    n_cmp++; if (frame_err !== 2'b01) begin n_bad++; $display("FAIL missing_sop_err: got %b want 01", frame_err); end
  endtask

  task automatic test_mid_reset();
    raddr = 8'd5;
    send_frame(120, -1, 3, 1'b1);
    n_cmp++; if (up_err !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_uperr: got %b want 1", up_err); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", word_count); end
    n_cmp++; if (up_err !== 1'b0) begin n_bad++; $display("FAIL midrst_uperr: got %b want 0", up_err); end
    n_cmp++; if (frame_err !== 2'b00 || frame_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got err=%b ready=%b want 00/0", frame_err, frame_ready); end
    n_cmp++; if ({rd_re, rd_im} !== '0) begin n_bad++; $display("FAIL midrst_read: got %h want 0", {rd_re, rd_im}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0002, 2'b00, 1'b0);
    n_cmp++; if (frame_err !== 2'b01) begin n_bad++; $display("FAIL midrst_nosop: got %b want 01", frame_err); end
    send_frame(LEN, LEN - 1, -1, 1'b1);
    n_cmp++; if (frame_ready !== 1'b1 || frame_err !== 2'b00) begin n_bad++; $display("FAIL midrst_next: got ready=%b err=%b want 1/00", frame_ready, frame_err); end
    release_frame();
  endtask

  task automatic test_up_error();
    for (int k = 0; k < LEN; k++) begin
      drive(1'b1, k == 0, k == LEN - 1, DW'(k), DW'(k), (k == 5) ? 2'b01 : 2'b00, 1'b0);
      if (k == 4) begin
        n_cmp++; if (up_err !== 1'b0) begin n_bad++; $display("FAIL uperr_before: got %b want 0", up_err); end
      end
      if (k == 5) begin
        n_cmp++; if (up_err !== 1'b1) begin n_bad++; $display("FAIL uperr_set: got %b want 1", up_err); end
      end
    end
    n_cmp++; if (up_err !== 1'b1 || frame_ready !== 1'b1) begin n_bad++; $display("FAIL uperr_full: got uperr=%b ready=%b want 1/1", up_err, frame_ready); end
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    n_cmp++; if (up_err !== 1'b1) begin n_bad++; $display("FAIL uperr_sticky: got %b want 1", up_err); end
    release_frame();
    n_cmp++; if (up_err !== 1'b0) begin n_bad++; $display("FAIL uperr_clear: got %b want 0", up_err); end
  endtask

  task automatic test_random();
    int n, eop_at, kind, k;
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       begin n = LEN; eop_at = LEN - 1; end
        1:       begin n = $urandom_range(1, LEN - 1); eop_at = n - 1; end
        2:       begin n = $urandom_range(LEN + 1, LEN + 30); eop_at = n - 1; end
        default: begin n = $urandom_range(1, 4); eop_at = -1; end
      endcase
      k = 0;
      while (k < n) begin
        if ($urandom_range(0, 4) == 0) begin
          drive(1'b0, 1'b1, 1'b1, DW'($urandom), DW'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
        end else begin
          drive(1'b1, (kind != 3) && (k == 0), k == eop_at, DW'($urandom), DW'($urandom),
                ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                $urandom_range(0, 15) == 0);
          k++;
        end
        n_cmp++;
        if (ready !== !m_held || frame_ready !== m_held || frame_err !== m_err || up_err !== m_up) begin
          n_bad++;
          $display("FAIL rand_flags f%0d w%0d: got rdy=%b fr=%b err=%b up=%b want %b/%b/%b/%b",
                   f, k, ready, frame_ready, frame_err, up_err, !m_held, m_held, m_err, m_up);
        end
      end
      if (m_held) begin
        n_cmp++; if (word_count !== 9'(LEN)) begin n_bad++; $display("FAIL rand_count f%0d: got %0d want %0d", f, word_count, LEN); end
        for (int j = 0; j < 4; j++) begin
          raddr = AW'($urandom);
          @(posedge clk); @(negedge clk);
          n_cmp++; if ({rd_re, rd_im} !== m_buf[raddr]) begin n_bad++; $display("FAIL rand_read f%0d a%0d: got %h want %h", f, raddr, {rd_re, rd_im}, m_buf[raddr]); end
        end
        repeat ($urandom_range(0, 5)) drive(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom), 2'b01, 1'b0);
        release_frame();
        n_cmp++; if (ready !== 1'b1 || up_err !== 1'b0) begin n_bad++; $display("FAIL rand_release f%0d: got rdy=%b up=%b want 1/0", f, ready, up_err); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 0; sop = 0; eop = 0; rel = 0;
    re = '0; im = '0; er = 2'b00; raddr = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_backpressure();
    test_early_eop();
    test_restart();
    test_overlong();
    test_mid_reset();
    test_up_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
